// File: rtl/j_sinerom_arb.sv
// Shares the single read port of the 1024x16 sine ROM between the DSP read path (A)
// and a strided table-walk burst engine (B), returning data two cycles after issue.
module j_sinerom_arb #(
  parameter int unsigned STARVE = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [9:0]  a_addr,
  output logic        a_gnt,
  output logic        a_valid,
  output logic [31:0] a_data,
  input  logic        b_start,
  input  logic [9:0]  b_base,
  input  logic [9:0]  b_count,
  input  logic [9:0]  b_stride,
  input  logic        b_ready,
  output logic        b_busy,
  output logic        b_valid,
  output logic [15:0] b_data,
  output logic        b_done,
  output logic [9:0]  roma,
  output logic        romen,
  input  logic [15:0] rom_q
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  logic        a_elig_s;
  logic        b_elig_s;
  logic        a_win_s;
  logic        b_win_s;
  logic        b_last_s;
  logic [3:0]  starve_cnt_r;
  logic        b_busy_r;
  logic [9:0]  b_addr_r;
  logic [9:0]  b_stride_r;
  logic [10:0] b_rem_r;
  logic        tag_vld_r;
  logic        tag_b_r;
  logic        tag_last_r;

  // Arbitration and ROM issue; A is masked during reset so nothing issues while held.
  always_comb begin
    a_elig_s = a_req & ~reset;
    b_elig_s = b_busy_r & b_ready;
    a_win_s  = 1'b0;
    b_win_s  = 1'b0;
    if (b_elig_s && (!a_elig_s || (starve_cnt_r == STARVE_MAX))) begin
      b_win_s = 1'b1;
    end else if (a_elig_s) begin
      a_win_s = 1'b1;
    end else begin
      a_win_s = 1'b0;
      b_win_s = 1'b0;
    end
    b_last_s = b_win_s && (b_rem_r == 11'd1);
    romen    = a_win_s | b_win_s;
    a_gnt    = a_win_s;
    if (b_win_s) begin
      roma = b_addr_r;
    end else if (a_win_s) begin
      roma = a_addr;
    end else begin
      roma = 10'd0;
    end
  end

  // Starvation counter: counts A wins that B lost while eligible.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (!b_elig_s || b_win_s) begin
      starve_cnt_r <= 4'd0;
    end else if (a_win_s && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Burst walker; a start pulse while busy (including the final issue cycle) is ignored.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      b_busy_r   <= 1'b0;
      b_addr_r   <= 10'd0;
      b_stride_r <= 10'd0;
      b_rem_r    <= 11'd0;
    end else if (!b_busy_r) begin
      if (b_start) begin
        b_busy_r   <= 1'b1;
        b_addr_r   <= b_base;
        b_stride_r <= b_stride;
        b_rem_r    <= (b_count == 10'd0) ? 11'd1024 : {1'b0, b_count};
      end else begin
        b_busy_r <= 1'b0;
      end
    end else if (b_win_s) begin
      b_addr_r <= b_addr_r + b_stride_r;
      b_rem_r  <= b_rem_r - 11'd1;
      b_busy_r <= (b_rem_r != 11'd1);
    end else begin
      b_busy_r <= 1'b1;
    end
  end

  // Tag pipe and return registers; rom_q is valid while stage 1 holds the issue.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      tag_vld_r  <= 1'b0;
      tag_b_r    <= 1'b0;
      tag_last_r <= 1'b0;
      a_valid    <= 1'b0;
      a_data     <= 32'd0;
      b_valid    <= 1'b0;
      b_data     <= 16'd0;
      b_done     <= 1'b0;
    end else begin
      tag_vld_r  <= romen;
      tag_b_r    <= b_win_s;
      tag_last_r <= b_last_s;
      a_valid    <= tag_vld_r & ~tag_b_r;
      b_valid    <= tag_vld_r & tag_b_r;
      b_done     <= tag_vld_r & tag_b_r & tag_last_r;
      if (tag_vld_r && !tag_b_r) begin
        a_data <= {{16{rom_q[15]}}, rom_q};
      end else begin
        a_data <= a_data;
      end
      if (tag_vld_r && tag_b_r) begin
        b_data <= rom_q;
      end else begin
        b_data <= b_data;
      end
    end
  end

  assign b_busy = b_busy_r;

endmodule

// File: tb/tb_j_sinerom_arb.sv
// Scoreboard bench for j_sinerom_arb: directed stimulus pushes expected returns,
// a negedge monitor pops and compares them whenever a valid pulse appears.
module tb_j_sinerom_arb;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0;
  logic [9:0]  a_addr = 10'd0;
  logic        a_gnt;
  logic        a_valid;
  logic [31:0] a_data;
  logic        b_start = 1'b0;
  logic [9:0]  b_base = 10'd0;
  logic [9:0]  b_count = 10'd0;
  logic [9:0]  b_stride = 10'd0;
  logic        b_ready = 1'b0;
  logic        b_busy;
  logic        b_valid;
  logic [15:0] b_data;
  logic        b_done;
  logic [9:0]  roma;
  logic        romen;
  logic [15:0] rom_q = 16'd0;

  j_sinerom_arb dut (
    .sys_clk(sys_clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_valid(a_valid), .a_data(a_data),
    .b_start(b_start), .b_base(b_base), .b_count(b_count), .b_stride(b_stride),
    .b_ready(b_ready), .b_busy(b_busy), .b_valid(b_valid), .b_data(b_data), .b_done(b_done),
    .roma(roma), .romen(romen), .rom_q(rom_q)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] rom_word(input logic [9:0] a);
    if (a == 10'h100) return 16'h8001;
    else if (a == 10'h101) return 16'h7FFF;
    else return {a[0], 5'h0A, a};
  endfunction

  // ROM model: one-cycle read latency
  always @(posedge sys_clk) if (romen) rom_q <= rom_word(roma);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [31:0] cyc;
  } exp_t;

  exp_t        aq[$];
  exp_t        bq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          b_valid_cnt = 0;
  int          b_done_cnt = 0;
  logic [31:0] cyc = 32'd0;
  logic [9:0]  eb_addr = 10'd0;
  logic [9:0]  eb_stride = 10'd0;
  int          eb_rem = 0;

  always @(posedge sys_clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every valid pulse
  always @(negedge sys_clk) begin
    if (!reset) begin
      exp_t e;
      if (a_valid || b_valid) check("one_valid", 32'(a_valid & b_valid), 32'd0);
      if (b_done && !b_valid) check("b_done_without_valid", 32'(b_done), 32'd0);
      if (a_valid) begin
        if (aq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_spurious: a_valid with data 0x%0h, expected no pulse", a_data);
        end else begin
          e = aq.pop_front();
          check("a_data", a_data, e.data);
          check("a_latency", cyc, e.cyc);
        end
      end
      if (b_valid) begin
        b_valid_cnt++;
        if (b_done) b_done_cnt++;
        if (bq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_spurious: b_valid with data 0x%0h, expected no pulse", b_data);
        end else begin
          e = bq.pop_front();
          check("b_data", 32'(b_data), e.data);
          check("b_done", 32'(b_done), 32'(e.last));
          check("b_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic next();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_a_issue(input logic [9:0] addr, input logic [31:0] data);
    check("a_gnt", 32'(a_gnt), 32'd1);
    check("a_romen", 32'(romen), 32'd1);
    check("a_roma", 32'(roma), 32'(addr));
    aq.push_back(exp_t'{data: data, last: 1'b0, cyc: cyc + 32'd2});
  endtask

  task automatic expect_b_issue(input bit push);
    check("b_romen", 32'(romen), 32'd1);
    check("b_no_a_gnt", 32'(a_gnt), 32'd0);
    check("b_roma", 32'(roma), 32'(eb_addr));
    if (push) bq.push_back(exp_t'{data: {16'd0, rom_word(eb_addr)}, last: (eb_rem == 1), cyc: cyc + 32'd2});
    eb_addr = eb_addr + eb_stride;
    eb_rem--;
  endtask

  task automatic expect_idle();
    check("idle_romen", 32'(romen), 32'd0);
    check("idle_a_gnt", 32'(a_gnt), 32'd0);
    check("idle_roma", 32'(roma), 32'd0);
  endtask

  task automatic start_burst(input logic [9:0] base, input logic [9:0] count, input logic [9:0] stride);
    b_base = base; b_count = count; b_stride = stride; b_start = 1'b1;
    eb_addr = base; eb_stride = stride; eb_rem = (count == 10'd0) ? 1024 : int'(count);
    @(negedge sys_clk);
    check("start_not_busy", 32'(b_busy), 32'd0);
    check("start_no_issue", 32'(romen), 32'd0);
    next();
    b_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (aq.size() != 0 || bq.size() != 0); i++) @(negedge sys_clk);
    check("drain_a", 32'(aq.size()), 32'd0);
    check("drain_b", 32'(bq.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_gnt"}, 32'(a_gnt), 32'd0);
    check({tag, "_a_valid"}, 32'(a_valid), 32'd0);
    check({tag, "_a_data"}, a_data, 32'd0);
    check({tag, "_b_busy"}, 32'(b_busy), 32'd0);
    check({tag, "_b_valid"}, 32'(b_valid), 32'd0);
    check({tag, "_b_data"}, 32'(b_data), 32'd0);
    check({tag, "_b_done"}, 32'(b_done), 32'd0);
    check({tag, "_romen"}, 32'(romen), 32'd0);
    check({tag, "_roma"}, 32'(roma), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int d0;
    logic [9:0] last_roma;
    last_roma = 10'd0;

    // Reset state
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check_all_zero("reset");
    next();
    reset = 1'b0;
    next();

    // A single reads, negative and positive sign extension
    a_req = 1'b1; a_addr = 10'h100;
    @(negedge sys_clk); expect_a_issue(10'h100, 32'hFFFF8001);
    next(); a_req = 1'b0;
    @(negedge sys_clk); expect_idle();
    next(); a_req = 1'b1; a_addr = 10'h101;
    @(negedge sys_clk); expect_a_issue(10'h101, 32'h00007FFF);
    next(); a_req = 1'b0;
    drain(); next();

    // B burst wrapping past 1023
    b_ready = 1'b1;
    start_burst(10'd1022, 10'd4, 10'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("wrap_busy", 32'(b_busy), 32'd1);
      expect_b_issue(1'b1);
      next();
    end
    @(negedge sys_clk);
    check("wrap_busy_clear", 32'(b_busy), 32'd0);
    expect_idle();
    drain(); next();

    // Starvation: A,A,A,A,B with both eligible; A every cycle with B stalled
    start_burst(10'd100, 10'd10, 10'd2);
    a_req = 1'b1; a_addr = 10'h050;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (i % 5 == 4) expect_b_issue(1'b1);
      else expect_a_issue(10'h050, 32'h00002850);
      next();
    end
    b_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk); expect_a_issue(10'h050, 32'h00002850);
      next();
    end
    a_req = 1'b0; b_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk); expect_b_issue(1'b1);
      next();
    end
    @(negedge sys_clk);
    check("starve_busy_clear", 32'(b_busy), 32'd0);
    drain(); next();

    // Backpressure: b_ready low for 5 cycles after the first issue
    v0 = b_valid_cnt;
    start_burst(10'd200, 10'd3, 10'd5);
    @(negedge sys_clk); expect_b_issue(1'b1);
    next(); b_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk); expect_idle();
      next();
    end
    b_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk); expect_b_issue(1'b1);
      next();
    end
    @(negedge sys_clk);
    check("bp_busy_clear", 32'(b_busy), 32'd0);
    drain();
    check("bp_valid_count", 32'(b_valid_cnt - v0), 32'd3);
    next();

    // b_count=0 means 1024 words; a start while busy is ignored
    v0 = b_valid_cnt; d0 = b_done_cnt;
    start_burst(10'd0, 10'd0, 10'd3);
    for (int i = 0; i < 1024; i++) begin
      @(negedge sys_clk);
      if (i == 1023) last_roma = roma;
      expect_b_issue(1'b1);
      next();
      b_start = (i == 100);
      b_base = 10'd500; b_count = 10'd7; b_stride = 10'd9;
    end
    b_start = 1'b0;
    @(negedge sys_clk);
    check("full_busy_clear", 32'(b_busy), 32'd0);
    check("full_last_addr", 32'(last_roma), 32'd1021);
    drain();
    check("full_valid_count", 32'(b_valid_cnt - v0), 32'd1024);
    check("full_done_count", 32'(b_done_cnt - d0), 32'd1);
    next();

    // Reset one cycle after a B issue, then a clean burst
    v0 = b_valid_cnt;
    start_burst(10'd10, 10'd5, 10'd1);
    @(negedge sys_clk); expect_b_issue(1'b0);
    next();
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    next(); next();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      expect_idle();
      check("midrst_busy", 32'(b_busy), 32'd0);
      next();
    end
    check("midrst_no_valid", 32'(b_valid_cnt - v0), 32'd0);
    start_burst(10'd300, 10'd3, 10'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk); expect_b_issue(1'b1);
      next();
    end
    @(negedge sys_clk);
    check("post_busy_clear", 32'(b_busy), 32'd0);
    drain();
    check("post_valid_count", 32'(b_valid_cnt - v0), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/j_sinerom_arb.md
# j_sinerom_arb

Arbiter and sequencer for the Jerry 1024×16 sine ROM. It shares the ROM's single read port between two requesters:
- the DSP data-bus read path (requester A), which does single random reads with sign extension to 32 bits;
- a table-walk engine (requester B), which does strided burst reads for wavetable/synthesis use.

The block drives the ROM address and enable, and returns read data with fixed latency to whichever requester issued the read.

## Interface
- STARVE, default 4: number of consecutive A grants allowed while B is eligible before B is forced a slot (range 1–15).

- sys_clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- a_req  in  1  A read request; held, with a_addr stable, until a_gnt.
- a_addr  in  10  A word address.
- a_gnt  out  1  combinational; high in the cycle A's read is issued.
- a_valid  out  1  registered one-cycle pulse, A read data valid.
- a_data  out  32  ROM word with ROM bit 15 replicated into bits 16–31; held between pulses.
- b_start  in  1  pulse; starts a burst when idle, ignored when busy.
- b_base  in  10  burst start address, sampled on an accepted b_start.
- b_count  in  10  burst length, sampled on an accepted b_start; 0 means 1024.
- b_stride  in  10  address increment, sampled on an accepted b_start.
- b_ready  in  1  consumer can accept a word two cycles after the current cycle.
- b_busy  out  1  registered; burst active.
- b_valid  out  1  registered one-cycle pulse, B data valid.
- b_data  out  16  raw ROM word; held between pulses.
- b_done  out  1  registered; coincides with the last b_valid of a burst.
- roma  out  10  ROM address.
- romen  out  1  ROM read enable (issue strobe).
- rom_q  in  16  ROM data, valid in the cycle after romen.

## Operation
- **Eligibility.** A is eligible when a_req=1. B is eligible when b_busy=1 and b_ready=1.
- **Arbitration (combinational, each cycle).**
  - Only A eligible: A wins.
  - Only B eligible: B wins.
  - Both eligible: A wins unless starve_cnt==STARVE, in which case B wins.
- **Starvation counter (starve_cnt, 4 bits).**
  - Increments on each A grant while B is eligible.
  - Clears on a B grant or in any cycle where B is not eligible.
  - Saturates at STARVE.
- **Issue.** In any cycle with a winner: romen=1, roma = the winner's address, and the winner's tag is pushed into a 2-stage tag pipe. In idle cycles: romen=0, roma=0.
- **B burst state.**
  - b_start while idle loads addr=b_base, remaining=b_count (0 → 1024), stride, and sets b_busy.
  - Each B issue sets addr ← (addr + stride) mod 1024 (10-bit wrap) and decrements remaining.
  - The issue that takes remaining to 0 clears b_busy on the next edge and marks its tag "last".
  - b_start in the same cycle b_busy clears is ignored.
- **Return.** Tag pipe stage 1 holds the issue of cycle N during cycle N+1. At the end of cycle N+1, rom_q is captured into a_data (sign-extended) or b_data, per tag. a_valid or b_valid, and b_done if tagged last, are high during cycle N+2.
- **Stride 0** is legal: the same word is read `count` times.

## Timing
- Read latency is 2 cycles from issue (romen/gnt) to valid. Throughput is 1 read/cycle total.
- A single A read with B idle: a_req rises in cycle N, a_gnt=1 in cycle N, a_valid=1 in cycle N+2.
- The first B issue is no earlier than the cycle after the accepted b_start.
- b_ready is sampled only at issue. Dropping it stalls issue but does not cancel words already in flight.
- Reset values: a_gnt=0, a_valid=0, a_data=0, b_busy=0, b_valid=0, b_data=0, b_done=0, romen=0, roma=0, starve_cnt=0, tag pipe empty.
- Reset mid-burst: the burst is aborted, in-flight reads are discarded with no valid pulse, and no b_done is issued.
- A and B never both receive data in the same cycle. At most one valid is asserted per cycle.

## Test plan
- **A single read.** Reset, then a_req=1, a_addr=0x100. Expect a_gnt in cycle 0 and a_valid in cycle 2. With rom_q=0x8001, expect a_data=0xFFFF8001. With rom_q=0x7FFF, expect a_data=0x00007FFF.
- **B burst wrap.** b_base=1022, b_count=4, b_stride=1, b_ready=1. Expect roma sequence 1022, 1023, 0, 1 on consecutive cycles, 4 b_valid pulses, and b_done with the 4th. Expect b_busy to clear one cycle after the last issue.
- **Starvation.** STARVE=4, A requests continuously with B eligible. Expect grant pattern A,A,A,A,B repeating. With B ineligible, expect A granted every cycle.
- **Backpressure.** During a b_count=3 burst, drop b_ready for 5 cycles after the first issue. Expect no B issues while low, the in-flight word still delivered, and 3 valids in total.
- **b_count=0.** Stride 3 from base 0. Expect 1024 issues, last address (1023·3) mod 1024 = 1021, and b_done once. Re-issuing b_start while busy changes nothing.
- **Reset mid-burst.** Assert reset one cycle after a B issue. Expect all outputs 0 immediately, no b_valid after deassertion, and a new burst that runs normally.
